// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding the HI/LO registers.
// Optional MDU_FLUSH_EN adds a flush input that cancels an in-flight op and blocks issue.
module e_mdu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MDU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             start,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdResult
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             flush_w;

`ifdef MDU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Result datapath works from the latched operands, so it is a multicycle path
  // of at least min(MUL_CYCLES, DIV_CYCLES) cycles into hi/lo.
  logic [2*WIDTH-1:0]      a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic signed [WIDTH-1:0] a_s, b_s, q_s, r_s;
  logic [WIDTH-1:0]        q_u, r_u;
  logic [WIDTH-1:0]        res_hi, res_lo;
  logic                    b_zero, div_ovf;

  always_comb begin
    a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    a_zx   = {{WIDTH{1'b0}}, a_q};
    b_zx   = {{WIDTH{1'b0}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
    a_s    = $signed(a_q);
    b_s    = $signed(b_q);
    b_zero = (b_q == '0);
    div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    q_s    = '0;
    r_s    = '0;
    q_u    = '0;
    r_u    = '0;
    if (!b_zero) begin
      q_s = a_s / b_s;
      r_s = a_s % b_s;
      q_u = a_q / b_q;
      r_u = a_q % b_q;
    end
  end

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        if (b_zero) begin
          res_lo = '1;
          res_hi = a_q;
        end else if (div_ovf) begin
          res_lo = a_q;
          res_hi = '0;
        end else begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      OpDivu: begin
        if (b_zero) begin
          res_lo = '1;
          res_hi = a_q;
        end else begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush_w) begin
          case (mdOp)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              op_d    = mdOp;
              a_d     = srcA;
              b_d     = srcB;
              cnt_d   = (mdOp == OpMult || mdOp == OpMultu) ? MulCnt : DivCnt;
              state_d = StRun;
            end
            OpMthi:  hi_d = srcA;
            OpMtlo:  lo_d = srcA;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (flush_w) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mdResult = '0;
    if (mdOp == OpMfhi) mdResult = hi_q;
    else if (mdOp == OpMflo) mdResult = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vectors, corner sequences and random ops vs a model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo, mdResult;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MDU_FLUSH_EN
    .flush    (flush),
`endif
    .start    (start),
    .mdOp     (mdOp),
    .srcA     (srcA),
    .srcB     (srcB),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .mdResult (mdResult)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural model: plain 64-bit arithmetic on the operation's meaning.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3, 4'd4: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 4'd3) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          m_lo = uq[31:0]; m_hi = ur[31:0];
        end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, count busy cycles, check hold behaviour and final HI/LO.
  // With noise set, mthi/mtlo starts are driven throughout RUN and must be ignored.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    int cnt;
    int exp_n;
    bit held_ok;
    @(negedge clk);
    start = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0; srcA = $urandom; srcB = $urandom;
    exp_n = (op == 4'd1 || op == 4'd2) ? 5 : (op == 4'd3 || op == 4'd4) ? 10 : 0;
    cnt = 0;
    held_ok = 1'b1;
    while (busy && cnt < 40) begin
      cnt++;
      if (hi !== m_hi || lo !== m_lo) held_ok = 1'b0;
      if (noise) begin
        start = 1'b1;
        mdOp  = (cnt % 2 == 0) ? 4'd8 : 4'd7;
        srcA  = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0; mdOp = 4'd0;
    model_apply(op, a, b);
    check({name, " busy cycles"}, 32'(cnt), 32'(exp_n));
    check({name, " hold"}, 32'(held_ok), 32'd1);
    check({name, " hi"}, hi, m_hi);
    check({name, " lo"}, lo, m_lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd4, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    vecs[7] = '{4'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[9] = '{4'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};

    reset = 1'b0; start = 1'b0; mdOp = 4'd0; srcA = '0; srcB = '0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset mdResult", mdResult, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("vec%0d table hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d table lo", i), lo, vecs[i].lo);
    end

    // mthi then mfhi next cycle; no busy
    @(negedge clk);
    start = 1'b1; mdOp = 4'd7; srcA = 32'h1234;
    @(negedge clk);
    check("mthi busy", 32'(busy), 32'd0);
    mdOp = 4'd5; srcA = 32'h5555;
    #1;
    check("mfhi result", mdResult, 32'h1234);
    m_hi = 32'h1234;
    mdOp = 4'd6;
    #1;
    check("mflo result", mdResult, m_lo);
    mdOp = 4'd0;
    #1;
    check("nope result", mdResult, 32'd0);
    start = 1'b0;

    // mthi/mtlo during a running divu are ignored, including on the completion edge
    run_op("divu noise", 4'd4, 32'd100, 32'd7, 1'b1);
    check("divu noise lo", lo, 32'd14);
    check("divu noise hi", hi, 32'd2);

    // Reset in the 3rd busy cycle of a mult
    @(negedge clk);
    start = 1'b1; mdOp = 4'd1; srcA = 32'd5; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("postreset lo", lo, 32'd0);
    run_op("divu 9/4", 4'd4, 32'd9, 32'd4, 1'b0);
    check("divu 9/4 lo", lo, 32'd2);
    check("divu 9/4 hi", hi, 32'd1);

`ifdef MDU_FLUSH_EN
    // Flush in 2nd busy cycle of div
    @(negedge clk);
    start = 1'b1; mdOp = 4'd3; srcA = 32'd50; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("flush hi", hi, m_hi);
    check("flush lo", lo, m_lo);
    // Flush with mthi in IDLE
    start = 1'b1; mdOp = 4'd7; srcA = 32'hABCD; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0; flush = 1'b0;
    check("flush mthi hi", hi, m_hi);
`endif

    // Random ops against the model
    for (int k = 0; k < 30; k++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0: op = 4'd1;
        1: op = 4'd2;
        2: op = 4'd3;
        3: op = 4'd4;
        4: op = 4'd7;
        default: op = 4'd8;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 17);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", k, op), op, a, b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
